instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Encoder counterpart to the main control decoder. Accepts symbolic instruction descriptors over a valid/ready stream.
- Packs each descriptor into a 32-bit instruction word using the same opcode/funct map the decoder consumes.
- Writes the words sequentially into instruction memory.
- Used as the program loader ahead of CPU release from reset, and as the stimulus generator for processor benches.

Parameters:
- ADDR_WIDTH, 32, width of instruction-memory byte address.
- CNT_WIDTH, 8, width of the word-count register; max program length is 2^CNT_WIDTH-1 words.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begin a load session (ignored unless idle).
- base_addr  input  ADDR_WIDTH  byte address of first word; sampled on start.
- count  input  CNT_WIDTH  number of words to write; sampled on start.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  loader can accept a descriptor.
- in_kind  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 SLTI, 10 J, 11 JAL, 12 JR; 13-15 illegal.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  16  immediate / branch offset.
- in_target  input  26  jump target field.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_WIDTH  write byte address.
- mem_wdata  output  32  encoded instruction.
- busy  output  1  session active.
- done  output  1  one-cycle pulse after final write.
- err  output  1  sticky illegal-kind flag; cleared on start.

Behaviour:
- Reset (async, immediate): state IDLE.
  - Outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0.
  - Internal address and word counters = 0.
- States: IDLE, ACCEPT, WRITE, FINISH.
- IDLE:
  - On start with count!=0: latch base_addr and count, clear err and the written counter; go to ACCEPT. busy=1 from the next cycle.
  - On start with count==0: go to FINISH directly.
- ACCEPT:
  - in_ready=1. On in_valid&in_ready, register the encoded word.
  - Legal kind: go to WRITE.
  - Illegal kind: set err, drop the word, stay in ACCEPT. Dropped words do not advance address or count.
- WRITE:
  - Exactly one cycle with mem_we=1, mem_addr=current address, mem_wdata=encoded word.
  - Then increment address by 4, modulo 2^ADDR_WIDTH, wrapping silently.
  - Increment written count. If written==count, go to FINISH; else go to ACCEPT.
  - in_ready=0 in WRITE, so the maximum rate is one word per 2 cycles.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Latency: handshake at cycle N gives mem_we at cycle N+1.
- start while busy: ignored. Session state is unaffected.
- Reset mid-session: session aborted; no partial write is issued after reset deasserts.
- Encoding, fields listed [31:26][25:21][20:16][15:11][10:6][5:0]:
  - R-type: 000000, rs, rt, rd, 00000, funct. funct: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - I-type: opcode, rs, rt, imm. Opcodes: LW 100011, SW 101011, BEQ 000100, ADDI 001001, SLTI 001010.
  - J 000010 and JAL 000011: opcode, target.
  - JR: 000110, rs, all remaining bits 0.
  - Unused descriptor fields are ignored, never ORed into the word.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Test Plan:
- start base=0x100, count=1; ADD rs=1 rt=2 rd=3 -> one write: addr 0x100, data 0x00221820; done pulse on the following cycle.
- count=3: LW rs=1 rt=2 imm=4, BEQ rs=1 rt=2 imm=0xFFFF, JAL target=0x10 -> writes 0x8C220004 at 0x100, 0x1022FFFF at 0x104, 0x0C000010 at 0x108.
- count=2: JR rs=31, then SLTI rs=4 rt=5 imm=0x8000 -> 0x1BE00000 at base, 0x28858000 at base+4; in_valid held high still yields exactly 2 writes, 2 cycles apart.
- count=1: kind=14, then ADDI rs=0 rt=8 imm=5 -> err=1; kind 14 produces no write; single write 0x24080005 at base; err stays 1 after done and clears on the next start.
- base=0xFFFFFFFC, count=2 -> writes at 0xFFFFFFFC then 0x00000000.
- Assert rst between handshake and WRITE -> no mem_we, all outputs 0 immediately; a new start after reset runs normally. Also: start with count=0 -> done pulse, no writes.

Source files
------------

// File: rtl/instr_encode_loader.sv
// Program loader: packs symbolic instruction descriptors into 32-bit words
// and writes them sequentially into instruction memory.
module instr_encode_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_kind,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_target,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, FINISH} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  written_q;
  logic [CNT_WIDTH-1:0]  written_inc;
  logic [31:0]           enc_word;
  logic                  kind_legal;
  logic                  handshake;

  assign in_ready    = (state == ACCEPT);
  assign busy        = (state == ACCEPT) || (state == WRITE);
  assign mem_we      = (state == WRITE);
  assign done        = (state == FINISH);
  assign handshake   = in_ready && in_valid;
  assign written_inc = written_q + CNT_WIDTH'(1);

  // Encode the descriptor; only the fields each format uses reach the word
  always_comb begin
    enc_word   = 32'h0000_0000;
    kind_legal = 1'b1;
    case (in_kind)
      4'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      4'd1:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      4'd2:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
      4'd3:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
      4'd4:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
      4'd5:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
      4'd6:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
      4'd7:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
      4'd8:    enc_word = {6'b001001, in_rs, in_rt, in_imm};
      4'd9:    enc_word = {6'b001010, in_rs, in_rt, in_imm};
      4'd10:   enc_word = {6'b000010, in_target};
      4'd11:   enc_word = {6'b000011, in_target};
      4'd12:   enc_word = {6'b000110, in_rs, 21'd0};
      default: kind_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one accepted descriptor per write, session ends after count words
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (count != '0) ? ACCEPT : FINISH;
        end
      end
      ACCEPT: begin
        if (handshake && kind_legal) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        state_next = (written_inc == count_q) ? FINISH : ACCEPT;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Session registers and the held write address/data presented during WRITE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      count_q   <= '0;
      written_q <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err       <= 1'b0;
            addr_q    <= base_addr;
            count_q   <= count;
            written_q <= '0;
          end
        end
        ACCEPT: begin
          if (handshake) begin
            if (kind_legal) begin
              mem_addr  <= addr_q;
              mem_wdata <= enc_word;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          addr_q    <= addr_q + ADDR_WIDTH'(4);
          written_q <= written_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: an encoding table plus
// hand-written multi-cycle sequences (back-to-back, illegal kind, wrap, reset).
module tb_instr_encode_loader;

  localparam int ADDR_WIDTH = 32;
  localparam int CNT_WIDTH  = 8;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  count;
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_kind;
  logic [4:0]            in_rs, in_rt, in_rd;
  logic [15:0]           in_imm;
  logic [25:0]           in_target;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  instr_encode_loader #(.ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time writes and done pulses
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log and done counter, sampled on the falling edge
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
  end

  // Global safety net
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] expected;
  } vec_t;

  vec_t table_v[13];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic startSession(input logic [31:0] b, input logic [7:0] n);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    count     = n;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    @(negedge clk);
    in_kind   = k;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_target = tgt;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) break;
    end
    checkOutput(name, {31'd0, done}, 32'd1);
  endtask

  task automatic checkWrite(input string name, input int idx, input logic [31:0] exp_addr,
                            input logic [31:0] exp_data);
    if (idx < wr_addr_q.size()) begin
      checkOutput({name, "_addr"}, wr_addr_q[idx], exp_addr);
      checkOutput({name, "_data"}, wr_data_q[idx], exp_data);
    end else begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: got no write at index %0d, required data %h", name, idx, exp_data);
    end
  endtask

  initial begin
    int n0;
    int d0;
    logic [31:0] b;

    // kind, rs, rt, rd, imm, target, expected; unused fields carry junk on purpose
    table_v[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h3FFFFFF, 32'h00221820};
    table_v[1]  = '{4'd1,  5'd4,  5'd5,  5'd6,  16'h1234, 26'h0000001, 32'h00853022};
    table_v[2]  = '{4'd2,  5'd7,  5'd8,  5'd9,  16'hFFFF, 26'h3FFFFFF, 32'h00E84824};
    table_v[3]  = '{4'd3,  5'd31, 5'd31, 5'd31, 16'h0000, 26'h0000000, 32'h03FFF825};
    table_v[4]  = '{4'd4,  5'd10, 5'd11, 5'd12, 16'hFFFF, 26'h3FFFFFF, 32'h014B602A};
    table_v[5]  = '{4'd5,  5'd1,  5'd2,  5'd31, 16'h0004, 26'h3FFFFFF, 32'h8C220004};
    table_v[6]  = '{4'd6,  5'd29, 5'd16, 5'd5,  16'hFFF8, 26'h3FFFFFF, 32'hAFB0FFF8};
    table_v[7]  = '{4'd7,  5'd1,  5'd2,  5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h1022FFFF};
    table_v[8]  = '{4'd8,  5'd0,  5'd8,  5'd31, 16'h0005, 26'h3FFFFFF, 32'h24080005};
    table_v[9]  = '{4'd9,  5'd4,  5'd5,  5'd31, 16'h8000, 26'h3FFFFFF, 32'h28858000};
    table_v[10] = '{4'd10, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h2ABCDEF, 32'h0AABCDEF};
    table_v[11] = '{4'd11, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010, 32'h0C000010};
    table_v[12] = '{4'd12, 5'd31, 5'd5,  5'd6,  16'h1234, 26'h3FFFFFF, 32'h1BE00000};

    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;

    // Reset state
    #12;
    checkOutput("rst_in_ready",  {31'd0, in_ready}, 32'd0);
    checkOutput("rst_mem_we",    {31'd0, mem_we},   32'd0);
    checkOutput("rst_mem_addr",  mem_addr,          32'd0);
    checkOutput("rst_mem_wdata", mem_wdata,         32'd0);
    checkOutput("rst_busy",      {31'd0, busy},     32'd0);
    checkOutput("rst_done",      {31'd0, done},     32'd0);
    checkOutput("rst_err",       {31'd0, err},      32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Encoding table, one single-word session per entry
    for (int i = 0; i < 13; i++) begin
      b  = 32'h100 + 32'(i) * 32'h10;
      n0 = wr_addr_q.size();
      startSession(b, 8'd1);
      checkOutput($sformatf("tbl%0d_busy", i), {31'd0, busy}, 32'd1);
      applyStimulus(table_v[i].kind, table_v[i].rs, table_v[i].rt, table_v[i].rd,
                    table_v[i].imm, table_v[i].target);
      waitDone($sformatf("tbl%0d_done", i));
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_nwrites", i), 32'(wr_addr_q.size() - n0), 32'd1);
      checkWrite($sformatf("tbl%0d", i), n0, b, table_v[i].expected);
      if (n0 < wr_cyc_q.size())
        checkOutput($sformatf("tbl%0d_done_cycle", i), 32'(last_done_cyc), 32'(wr_cyc_q[n0] + 1));
    end

    // Three-word program
    n0 = wr_addr_q.size();
    startSession(32'h100, 8'd3);
    applyStimulus(4'd5,  5'd1, 5'd2, 5'd0, 16'h0004, 26'd0);
    applyStimulus(4'd7,  5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0);
    applyStimulus(4'd11, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h10);
    waitDone("seq3_done");
    @(negedge clk);
    checkOutput("seq3_nwrites", 32'(wr_addr_q.size() - n0), 32'd3);
    checkWrite("seq3_w0", n0,     32'h100, 32'h8C220004);
    checkWrite("seq3_w1", n0 + 1, 32'h104, 32'h1022FFFF);
    checkWrite("seq3_w2", n0 + 2, 32'h108, 32'h0C000010);

    // in_valid held high across two descriptors
    n0 = wr_addr_q.size();
    startSession(32'h200, 8'd2);
    @(negedge clk);
    in_kind = 4'd12; in_rs = 5'd31; in_rt = 5'd0; in_rd = 5'd0; in_imm = '0; in_target = '0;
    in_valid = 1'b1;
    @(negedge clk);
    in_kind = 4'd9; in_rs = 5'd4; in_rt = 5'd5; in_imm = 16'h8000;
    waitDone("held_done");
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("held_nwrites", 32'(wr_addr_q.size() - n0), 32'd2);
    checkWrite("held_w0", n0,     32'h200, 32'h1BE00000);
    checkWrite("held_w1", n0 + 1, 32'h204, 32'h28858000);
    if (n0 + 1 < wr_cyc_q.size())
      checkOutput("held_spacing", 32'(wr_cyc_q[n0 + 1] - wr_cyc_q[n0]), 32'd2);

    // Illegal kind is dropped and flagged
    n0 = wr_addr_q.size();
    startSession(32'h300, 8'd1);
    applyStimulus(4'd14, 5'd3, 5'd3, 5'd3, 16'h1111, 26'h2222);
    @(negedge clk);
    checkOutput("ill_err",     {31'd0, err},  32'd1);
    checkOutput("ill_busy",    {31'd0, busy}, 32'd1);
    checkOutput("ill_nwrites", 32'(wr_addr_q.size() - n0), 32'd0);
    applyStimulus(4'd8, 5'd0, 5'd8, 5'd0, 16'h0005, 26'd0);
    waitDone("ill_done");
    @(negedge clk);
    checkOutput("ill_err_after_done", {31'd0, err}, 32'd1);
    checkOutput("ill_nwrites_final", 32'(wr_addr_q.size() - n0), 32'd1);
    checkWrite("ill_w0", n0, 32'h300, 32'h24080005);

    // Address wrap; also the start that clears err
    n0 = wr_addr_q.size();
    startSession(32'hFFFFFFFC, 8'd2);
    checkOutput("wrap_err_cleared", {31'd0, err}, 32'd0);
    applyStimulus(4'd0, 5'd1,  5'd2,  5'd3,  16'd0, 26'd0);
    applyStimulus(4'd3, 5'd31, 5'd31, 5'd31, 16'd0, 26'd0);
    waitDone("wrap_done");
    @(negedge clk);
    checkOutput("wrap_nwrites", 32'(wr_addr_q.size() - n0), 32'd2);
    checkWrite("wrap_w0", n0,     32'hFFFFFFFC, 32'h00221820);
    checkWrite("wrap_w1", n0 + 1, 32'h00000000, 32'h03FFF825);

    // Reset between handshake and write
    startSession(32'h400, 8'd1);
    @(negedge clk);
    in_kind = 4'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_valid = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    n0 = wr_addr_q.size();
    d0 = done_cnt;
    checkOutput("mid_rst_mem_we",    {31'd0, mem_we},   32'd0);
    checkOutput("mid_rst_mem_addr",  mem_addr,          32'd0);
    checkOutput("mid_rst_mem_wdata", mem_wdata,         32'd0);
    checkOutput("mid_rst_in_ready",  {31'd0, in_ready}, 32'd0);
    checkOutput("mid_rst_busy",      {31'd0, busy},     32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mid_rst_no_write", 32'(wr_addr_q.size() - n0), 32'd0);
    checkOutput("mid_rst_no_done",  32'(done_cnt - d0),        32'd0);
    n0 = wr_addr_q.size();
    startSession(32'h500, 8'd1);
    applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    waitDone("post_rst_done");
    @(negedge clk);
    checkOutput("post_rst_nwrites", 32'(wr_addr_q.size() - n0), 32'd1);
    checkWrite("post_rst_w0", n0, 32'h500, 32'h00221820);

    // Zero-length session: done pulse only
    n0 = wr_addr_q.size();
    d0 = done_cnt;
    startSession(32'h600, 8'd0);
    checkOutput("zero_done",  {31'd0, done}, 32'd1);
    checkOutput("zero_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("zero_done_pulse", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("zero_nwrites", 32'(wr_addr_q.size() - n0), 32'd0);
    checkOutput("zero_done_cnt", 32'(done_cnt - d0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
